// File: rtl/limb_fetch.sv
// limb_fetch: Limb CPU fetch stage (PC, ROM addressing, decoder handshake, hardware call stack); define LIMB_FETCH_RAS_CHECK_EN to halt on stack faults
module limb_fetch #(
  parameter int RAS_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [7:0]                 rom_addr,
  input  logic [31:0]                rom_data,
  output logic [31:0]                ir,
  output logic [7:0]                 ir_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  input  logic                       br_take,
  input  logic                       call_take,
  input  logic                       ret_take,
  input  logic [7:0]                 target,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_err
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] C1 = 1;
  localparam logic [PW-1:0] P1 = 1;
`ifdef LIMB_FETCH_RAS_CHECK_EN
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  logic r_err, w_err_n, w_fault;
`else
  typedef enum logic {RUN, FLUSH} state_t;
`endif
  state_t r_state, w_state_n;
  logic [7:0] r_pc, w_pc_n, r_ir_pc, w_ir_pc_n;
  logic [31:0] r_ir, w_ir_n;
  logic r_valid, w_valid_n, w_push, w_fire, w_redir, w_full, w_empty;
  logic [PW:0] r_cnt, w_cnt_n;
  logic [PW-1:0] r_wp, w_wp_n, w_top;
  logic [7:0] r_stack [RAS_DEPTH];

  assign w_fire  = r_valid & ir_ready;
  assign w_redir = br_take | call_take | ret_take;
  assign w_full  = r_cnt == (PW+1)'(RAS_DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_top   = r_wp - P1;
`ifdef LIMB_FETCH_RAS_CHECK_EN
  assign w_fault = ret_take ? w_empty : call_take & w_full;
  assign ras_err = r_err;
`else
  assign ras_err = 1'b0;
`endif
  assign rom_addr  = r_pc;
  assign ir        = r_ir;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_valid;
  assign ras_count = r_cnt;

  // next-state: flush bubble, redirect handling (ret > call > br), or sequential fetch
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_ir_n    = r_ir;
    w_ir_pc_n = r_ir_pc;
    w_valid_n = r_valid;
    w_cnt_n   = r_cnt;
    w_wp_n    = r_wp;
    w_push    = 1'b0;
`ifdef LIMB_FETCH_RAS_CHECK_EN
    w_err_n   = r_err;
`endif
    if (r_state == FLUSH) w_state_n = RUN;
    else if (r_state == RUN && w_fire && w_redir) begin
      w_valid_n = 1'b0;
      w_state_n = FLUSH;
`ifdef LIMB_FETCH_RAS_CHECK_EN
      if (w_fault) begin
        w_state_n = HALT;
        w_err_n   = 1'b1;
      end else
`endif
      if (ret_take) begin
        w_pc_n  = r_stack[w_top];
        w_wp_n  = w_top;
        w_cnt_n = w_empty ? r_cnt : r_cnt - C1;
      end else if (call_take) begin
        w_push  = 1'b1;
        w_pc_n  = target;
        w_wp_n  = r_wp + P1;
        w_cnt_n = w_full ? r_cnt : r_cnt + C1;
      end else w_pc_n = target;
    end else if (r_state == RUN && (w_fire || !r_valid)) begin
      w_ir_n    = rom_data;
      w_ir_pc_n = r_pc;
      w_valid_n = 1'b1;
      w_pc_n    = r_pc + 8'd1;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ir_pc <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_wp    <= '0;
`ifdef LIMB_FETCH_RAS_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_ir    <= w_ir_n;
      r_ir_pc <= w_ir_pc_n;
      r_valid <= w_valid_n;
      r_cnt   <= w_cnt_n;
      r_wp    <= w_wp_n;
`ifdef LIMB_FETCH_RAS_CHECK_EN
      r_err   <= w_err_n;
`endif
    end
  end

  // circular return-address storage; contents survive reset
  always_ff @(posedge clk) if (!reset && w_push) r_stack[r_wp] <= r_ir_pc + 8'd1;
endmodule

// File: tb/tb_limb_fetch.sv
// tb_limb_fetch: randomized and directed check of limb_fetch against a queue-based fetch model
module tb_limb_fetch;
  localparam int D = 4;
`ifdef LIMB_FETCH_RAS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, reset = 1, ir_ready = 0, br_take = 0, call_take = 0, ret_take = 0;
  logic [7:0] target = 0, rom_addr, ir_pc;
  logic [31:0] rom_data, ir;
  logic ir_valid, ras_err;
  logic [2:0] ras_count;
  logic [31:0] rom [256];
  int n_tot = 0, n_bad = 0;
  int m_pc, m_irpc, m_valid, m_flush, m_halt, m_err;
  logic [31:0] m_ir;
  int q[$];
  int links [4] = '{32'h91, 32'h81, 32'h71, 32'h61};

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  limb_fetch #(.RAS_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_take(br_take), .call_take(call_take), .ret_take(ret_take),
    .target(target), .ras_count(ras_count), .ras_err(ras_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0; m_flush = 0; m_halt = 0; m_err = 0;
      q.delete();
    end else if (m_halt) begin
    end else if (m_flush) m_flush = 0;
    else if (!m_valid || ir_ready) begin
      if (m_valid && (ret_take || call_take || br_take)) begin
        if (CHK && (ret_take ? q.size() == 0 : call_take && q.size() == D)) begin
          m_err = 1; m_halt = 1; m_valid = 0;
        end else begin
          m_valid = 0; m_flush = 1;
          if (ret_take) m_pc = q.pop_back();
          else if (call_take) begin
            if (q.size() == D) void'(q.pop_front());
            q.push_back((m_irpc + 1) % 256);
            m_pc = target;
          end else m_pc = target;
        end
      end else begin
        m_ir = rom[m_pc]; m_irpc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".ir"}, ir, m_ir);
    chk({tag, ".ir_pc"}, ir_pc, m_irpc);
    chk({tag, ".valid"}, ir_valid, m_valid);
    chk({tag, ".rom_addr"}, rom_addr, m_pc);
    chk({tag, ".ras_count"}, ras_count, q.size());
    chk({tag, ".ras_err"}, ras_err, m_err);
  endtask

  task automatic wait_pc(input int p);
    int k = 0;
    {br_take, call_take, ret_take} = 3'b0;
    ir_ready = 1;
    while (!(m_valid && (p < 0 || m_irpc == p)) && k < 600) begin
      tick("run");
      k++;
    end
    if (!(m_valid && (p < 0 || m_irpc == p))) chk("wait_timeout", 0, 1);
  endtask

  task automatic fire(input logic b, input logic c, input logic r, input logic [7:0] t);
    br_take = b; call_take = c; ret_take = r; target = t; ir_ready = 1;
    tick("fire");
    {br_take, call_take, ret_take} = 3'b0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) tick("rst");
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    reset = 1;
    repeat (3) tick("rst");
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 0; ir_ready = 1;
    tick("e1"); chk("e1_ir", ir, 32'h11); chk("e1_pc", ir_pc, 0); chk("e1_v", ir_valid, 1);
    tick("e2"); chk("e2_ir", ir, 32'h22); chk("e2_pc", ir_pc, 1);
    tick("e3"); chk("e3_ir", ir, 32'h33); chk("e3_pc", ir_pc, 2);
    ir_ready = 0;
    repeat (5) begin
      tick("stall");
      chk("stall_ir", ir, 32'h33); chk("stall_pc", ir_pc, 2); chk("stall_addr", rom_addr, 3);
    end
    ir_ready = 1;
    tick("e4"); chk("e4_ir", ir, 32'h44); chk("e4_pc", ir_pc, 3);
    wait_pc(5);
    br_take = 1; target = 8'h80; ir_ready = 0;
    tick("br_nofire"); chk("br_nofire_pc", ir_pc, 5); chk("br_nofire_v", ir_valid, 1);
    fire(1, 0, 0, 8'h80); chk("br_bub0", ir_valid, 0);
    tick("bub"); chk("br_bub1", ir_valid, 0);
    tick("land"); chk("br_land_pc", ir_pc, 8'h80); chk("br_land_v", ir_valid, 1);
    wait_pc(8'h10);
    fire(0, 1, 0, 8'h40); chk("call_cnt", ras_count, 1);
    wait_pc(8'h42);
    fire(0, 0, 1, 8'h00); chk("ret_cnt", ras_count, 0);
    tick("b"); tick("b"); chk("ret_pc", ir_pc, 8'h11);
    fire(1, 0, 0, 8'hFF); tick("b"); tick("b"); chk("ff_pc", ir_pc, 8'hFF);
    fire(0, 1, 0, 8'h20); tick("b"); tick("b");
    fire(0, 0, 1, 8'h00); tick("b"); tick("b"); chk("wrap_ret_pc", ir_pc, 8'h00);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_pc(-1);
      fire(0, 1, 0, 8'(8'h60 + 8'h10 * i));
    end
`ifdef LIMB_FETCH_RAS_CHECK_EN
    chk("ovf_err", ras_err, 1); chk("ovf_v", ir_valid, 0);
    ir_ready = 1; br_take = 1; target = 8'h05;
    repeat (4) begin
      tick("halt");
      chk("halt_v", ir_valid, 0); chk("halt_addr", rom_addr, 8'h91);
    end
    br_take = 0;
    do_reset();
    chk("rst_err", ras_err, 0);
    tick("restart"); chk("restart_pc", ir_pc, 0); chk("restart_v", ir_valid, 1);
`else
    chk("ovf_cnt", ras_count, 4);
    for (int i = 0; i < 4; i++) begin
      wait_pc(-1);
      fire(0, 0, 1, 8'h00); tick("b"); tick("b");
      chk("ovf_ret_pc", ir_pc, links[i]);
    end
    chk("ovf_empty", ras_count, 0);
`endif
    do_reset();
    wait_pc(8'h2F);
    fire(0, 1, 0, 8'h50); tick("b"); tick("b");
    fire(1, 1, 1, 8'h77); chk("pri_cnt", ras_count, 0);
    tick("b"); chk("pri_addr", rom_addr, 8'h30);
    tick("b"); chk("pri_pc", ir_pc, 8'h30);
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom % 10;
      reset = ($urandom % 400) == 0;
      ir_ready = ($urandom % 4) != 0;
      target = 8'($urandom);
      br_take = (r == 0) || (r == 3);
      call_take = ((r == 1) || (r == 3)) && (!CHK || q.size() < D);
      ret_take = ((r == 2) || (r == 3)) && q.size() > 0;
      tick("rnd");
    end
    reset = 0;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
